// File: rtl/imm_alloc.sv
// Group allocator for the 4-wide immediate register file: round-robin grant of free 4-entry groups.
// Optional stall-cycle counter (o_stall_cnt) is built only when IMM_ALLOC_STATS_EN is defined.
module imm_alloc #(
    parameter  int WIDTH_ADDR = 5,
    localparam int NGROUP     = (2**WIDTH_ADDR) / 4,
    localparam int GW         = WIDTH_ADDR - 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_alloc,
    input  logic                  i_free,
    input  logic [GW-1:0]         i_free_grp,
    input  logic                  i_flush,
    output logic                  o_ready,
    output logic                  o_we,
    output logic [NGROUP-1:0]     o_waddr,
    output logic [GW-1:0]         o_grp,
    output logic [WIDTH_ADDR-1:0] o_base,
    output logic [GW:0]           o_count,
    output logic                  o_dbl_free
`ifdef IMM_ALLOC_STATS_EN
    ,
    output logic [15:0]           o_stall_cnt
`endif
);

    logic [NGROUP-1:0] free_mask_reg, free_mask_next;
    logic [GW-1:0]     ptr_reg, ptr_next;
    logic [GW:0]       count_reg, count_next;
    logic              dbl_free_reg, dbl_free_next;

    logic [NGROUP-1:0] rot_mask;
    logic [GW-1:0]     offset;
    logic [GW-1:0]     grant_grp;
    logic              grant;
    logic              free_eff;
    logic              free_dbl;
    logic [NGROUP-1:0] free_onehot;

    // Mask rotated so that bit 0 is the group at the search pointer.
    generate
        for (genvar gi = 0; gi < NGROUP; gi++) begin : g_rot
            assign rot_mask[gi] = free_mask_reg[ptr_reg + GW'(gi)];
        end
    endgenerate

    always_comb begin
        offset = '0;
        for (int k = NGROUP - 1; k >= 0; k--) begin
            if (rot_mask[k]) begin
                offset = GW'(k);
            end
        end
        grant_grp = ptr_reg + offset;
        o_ready   = |free_mask_reg;
        grant     = i_alloc & o_ready & ~i_flush;
        o_we      = grant;
        o_grp     = grant ? grant_grp : '0;
        o_waddr   = grant ? (NGROUP'(1) << grant_grp) : '0;
        o_base    = {o_grp, 2'b00};
    end

    // A free only counts when the group is actually in use.
    always_comb begin
        free_dbl    = i_free & free_mask_reg[i_free_grp];
        free_eff    = i_free & ~free_mask_reg[i_free_grp];
        free_onehot = free_eff ? (NGROUP'(1) << i_free_grp) : '0;
    end

    always_comb begin
        free_mask_next = free_mask_reg;
        ptr_next       = ptr_reg;
        count_next     = count_reg;
        dbl_free_next  = 1'b0;
        if (i_flush) begin
            free_mask_next = '1;
            ptr_next       = '0;
            count_next     = (GW+1)'(NGROUP);
        end else begin
            free_mask_next = (free_mask_reg & ~o_waddr) | free_onehot;
            if (grant) begin
                ptr_next = grant_grp + GW'(1);
            end
            count_next    = count_reg + (GW+1)'(free_eff) - (GW+1)'(grant);
            dbl_free_next = free_dbl;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            free_mask_reg <= '1;
            ptr_reg       <= '0;
            count_reg     <= (GW+1)'(NGROUP);
            dbl_free_reg  <= 1'b0;
        end else begin
            free_mask_reg <= free_mask_next;
            ptr_reg       <= ptr_next;
            count_reg     <= count_next;
            dbl_free_reg  <= dbl_free_next;
        end
    end

    assign o_count    = count_reg;
    assign o_dbl_free = dbl_free_reg;

`ifdef IMM_ALLOC_STATS_EN
    // Survives flush on purpose: it measures stalls across the whole run.
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_reg <= '0;
        end else if (i_alloc && !o_ready && !i_flush && stall_cnt_reg != 16'hFFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_imm_alloc.sv
// Randomized scoreboard bench for imm_alloc: a driver pushes model expectations, a negedge monitor pops and compares.
module tb_imm_alloc;
    localparam int WA = 5;
    localparam int NG = 8;
    localparam int GW = 3;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_alloc = 1'b0;
    logic          i_free = 1'b0;
    logic [GW-1:0] i_free_grp = '0;
    logic          i_flush = 1'b0;
    logic          o_ready, o_we, o_dbl_free;
    logic [NG-1:0] o_waddr;
    logic [GW-1:0] o_grp;
    logic [WA-1:0] o_base;
    logic [GW:0]   o_count;
`ifdef IMM_ALLOC_STATS_EN
    logic [15:0]   o_stall_cnt;
`endif

    always #5 i_clk = ~i_clk;

    imm_alloc #(.WIDTH_ADDR(WA)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_alloc(i_alloc), .i_free(i_free),
        .i_free_grp(i_free_grp), .i_flush(i_flush), .o_ready(o_ready), .o_we(o_we),
        .o_waddr(o_waddr), .o_grp(o_grp), .o_base(o_base), .o_count(o_count),
        .o_dbl_free(o_dbl_free)
`ifdef IMM_ALLOC_STATS_EN
        , .o_stall_cnt(o_stall_cnt)
`endif
    );

    typedef struct {
        bit          chk;
        bit          ready;
        bit          we;
        logic [7:0]  waddr;
        logic [2:0]  grp;
        logic [4:0]  base;
        logic [3:0]  count;
        bit          dbl;
        logic [15:0] stall;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_txn = 0;

    // Reference model: which groups are free, where the search starts, pending double-free flag.
    bit fm[NG];
    int ptr_m = 0;
    bit dbl_m = 0;
    int stall_m = 0;

    task automatic step(input bit a, input bit f, input int fg, input bit fl, input bit r);
        exp_t e;
        bit   rdy;
        bit   fm0[NG];
        int   g;
        int   nfree;
        @(posedge i_clk);
        #1;
        i_alloc    = a;
        i_free     = f;
        i_free_grp = 3'(fg);
        i_flush    = fl;
        i_rst      = r;
        rdy = 0;
        nfree = 0;
        foreach (fm[i]) begin
            if (fm[i]) begin
                rdy = 1;
                nfree++;
            end
        end
        g = -1;
        for (int k = 0; k < NG; k++) begin
            if (g < 0 && fm[(ptr_m + k) % NG]) g = (ptr_m + k) % NG;
        end
        e.chk   = !r;
        e.ready = rdy;
        e.we    = a && rdy && !fl;
        e.grp   = e.we ? 3'(g) : 3'd0;
        e.waddr = e.we ? 8'(1 << g) : 8'd0;
        e.base  = e.we ? 5'(g * 4) : 5'd0;
        e.count = 4'(nfree);
        e.dbl   = dbl_m;
        e.stall = 16'(stall_m);
        q.push_back(e);
        if (r) stall_m = 0;
        else if (a && !rdy && !fl && stall_m < 65535) stall_m++;
        if (r || fl) begin
            foreach (fm[i]) fm[i] = 1;
            ptr_m = 0;
            dbl_m = 0;
        end else begin
            fm0 = fm;
            dbl_m = f && fm0[fg];
            if (e.we) begin
                fm[g] = 0;
                ptr_m = (g + 1) % NG;
            end
            if (f && !fm0[fg]) fm[fg] = 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic allocs(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL txn %0d %s: got %0h required %0h", n_txn, name, act, req);
        end
    endtask

    exp_t mon_e;
    always @(negedge i_clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            n_txn++;
            if (mon_e.chk) begin
                cmp("ready", 16'(o_ready), 16'(mon_e.ready));
                cmp("we", 16'(o_we), 16'(mon_e.we));
                cmp("waddr", 16'(o_waddr), 16'(mon_e.waddr));
                cmp("grp", 16'(o_grp), 16'(mon_e.grp));
                cmp("base", 16'(o_base), 16'(mon_e.base));
                cmp("count", 16'(o_count), 16'(mon_e.count));
                cmp("dbl_free", 16'(o_dbl_free), 16'(mon_e.dbl));
`ifdef IMM_ALLOC_STATS_EN
                cmp("stall_cnt", o_stall_cnt, mon_e.stall);
`endif
                if (n_txn <= 80)
                    $display("txn %0d: we=%0b grp=%0d waddr=%02h base=%0d count=%0d ready=%0b dbl=%0b",
                             n_txn, o_we, o_grp, o_waddr, o_base, o_count, o_ready, o_dbl_free);
            end
        end
    end

    initial begin
        foreach (fm[i]) fm[i] = 1;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        idle(1);
        allocs(8);
        step(1, 0, 0, 0, 0);
        idle(1);
        step(0, 1, 3, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 1, 0);
        allocs(6);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        allocs(3);
        idle(1);
        step(0, 0, 0, 1, 0);
        allocs(7);
        step(1, 1, 2, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 1, 0);
        allocs(3);
        step(0, 1, 4, 0, 0);
        idle(2);
        step(0, 0, 0, 1, 0);
        allocs(5);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 1, 0);
        allocs(8);
        allocs(3);
        step(1, 0, 0, 1, 0);
        step(0, 1, 1, 0, 1);
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, int'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
        end
        idle(2);
        @(posedge i_clk);
        @(posedge i_clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d entries left required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/imm_alloc.md
# imm_alloc

Group allocator for the 4-wide immediate register file. It tracks which 4-entry groups of the file are in use and grants one free group per dispatch bundle. For the granted group it drives the one-hot group write-enable and the base read address, and it returns groups to the free pool on commit or flush. It sits between the dispatch stage and the immediate file, and stalls dispatch when no group is free.

## Interface
- `WIDTH_ADDR`, 5, immediate-file address width; `NGROUP = 2**WIDTH_ADDR/4` groups (8 by default); `GW = WIDTH_ADDR-2` group-index bits.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_alloc`  in  1  dispatch requests one group this cycle.
- `i_free`  in  1  release the group on `i_free_grp`.
- `i_free_grp`  in  GW  group index to release.
- `i_flush`  in  1  pipeline flush: release all groups.
- `o_ready`  out  1  at least one group is free (combinational from state).
- `o_we`  out  1  write enable to the immediate file; `= i_alloc & o_ready & ~i_flush`.
- `o_waddr`  out  NGROUP  one-hot group select to the immediate file; all zero when `o_we=0`.
- `o_grp`  out  GW  granted group index; valid when `o_we=1`.
- `o_base`  out  WIDTH_ADDR  `{o_grp, 2'b00}`; the bundle's four immediates sit at `o_base+0..3`.
- `o_count`  out  GW+1  registered number of free groups.
- `o_dbl_free`  out  1  registered one-cycle pulse when a free hits a group that is already free.
- `o_stall_cnt`  out  16  stall-cycle counter; present only with `IMM_ALLOC_STATS_EN`.

## Operation
- State:
  - `free_mask[NGROUP]`: bit = 1 means the group is free.
  - `ptr[GW]`: round-robin search start.
  - `count`
  - `o_dbl_free`
- Grant selection (combinational): the first group with `free_mask=1` scanning `ptr, ptr+1, …` modulo NGROUP.
- On grant:
  - the granted bit is cleared at the edge;
  - `ptr` becomes `grant+1` (wraps from NGROUP-1 to 0).
- Free:
  - if `free_mask[i_free_grp]=0`, that bit is set at the edge;
  - otherwise the mask is unchanged and `o_dbl_free` goes to 1 for the next cycle.
- Simultaneous alloc and free in the same cycle:
  - both apply;
  - the freed group is not grantable until the next cycle, because grant uses the current mask;
  - `count` is unchanged.
- `count` update: `count + free_effective - grant`, where `free_effective` excludes double frees. It never exceeds NGROUP and never underflows.
- Flush:
  - priority over alloc and free;
  - `free_mask` becomes all ones, `ptr=0`, `count=NGROUP`;
  - `o_we=0` and `o_dbl_free=0` that cycle.
- Reset: same values as flush. Reset also applies mid-allocation; any grant in the reset cycle is discarded.
- Full (`count=0`): `o_ready=0`, `o_we=0`, state unchanged except for frees.

## Timing
- Grant latency 0:
  - `o_we`, `o_waddr`, `o_grp` and `o_base` are valid in the same cycle as `i_alloc`;
  - the immediate file captures the data at that same edge.
- Mask, pointer and count change at the edge after the request. `o_count` reflects a grant or free one cycle later.
- `o_dbl_free` is asserted for exactly one cycle, the cycle after the offending free.
- Back-to-back allocs every cycle are supported until the file is full. Throughput is 1 group per cycle.
- Reset values:
  - `o_ready=1`, `o_we=0`, `o_waddr=0`, `o_grp=0`, `o_base=0`;
  - `o_count=NGROUP`, `o_dbl_free=0`, `o_stall_cnt=0`.

## Configuration
- `IMM_ALLOC_STATS_EN` defined:
  - `o_stall_cnt` exists;
  - it increments at each edge where `i_alloc=1`, `o_ready=0` and `i_flush=0`;
  - it saturates at 16'hFFFF;
  - it is cleared only by `i_rst`, not by flush.
- `IMM_ALLOC_STATS_EN` not defined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- Reset, then 8 consecutive cycles of `i_alloc=1`:
  - grants in order `o_grp` 0,1,…,7;
  - `o_waddr` runs 8'h01 … 8'h80;
  - `o_base` runs 0,4,…,28;
  - cycle 9: `o_ready=0`, `o_we=0`, `o_count=0`.
- From full, free group 3, then alloc next cycle:
  - `o_grp=3`, `o_waddr=8'h08`;
  - `o_count` goes 0→1→0.
- Wrap-around:
  - allocate 0–5, free 0 and 1, allocate three times;
  - grants are 6, 7, 0 (`ptr` wraps from 7 to 0).
- Same-cycle alloc and free, with groups 0–7 in use except 7:
  - `i_alloc=1` and free group 2;
  - grant is 7, `o_count` stays at 1, group 2 is granted next cycle.
- Free group 4 while it is already free: `o_dbl_free=1` for one cycle, `o_count` unchanged.
- Flush with mixed occupancy:
  - flush with `i_alloc=1` and 5 groups in use;
  - `o_we=0` that cycle;
  - next cycle `o_count=8`, next grant is 0.
- With `IMM_ALLOC_STATS_EN`, hold `i_alloc` high for 3 cycles while full: `o_stall_cnt=3`.
